// File: rtl/link_frame_check.sv
// link_frame_check
// ----------------
// Receive-side framing stage placed directly after the 36-bit clock-domain
// data synchronizer. The synchronizer delivers one word per clock and has no
// valid strobe. Each word carries a control tag in [35:32] and a payload in
// [31:0]. This block delineates frames (SOF / DATA... / EOF), checks the word
// count and the 32-bit additive checksum of each frame, forwards the accepted
// payload words, and keeps saturating good-frame and error counters.
//
// Ports
//   clk        receive clock (synchronizer output side)
//   init       synchronous active-high reset
//   datain     [35:32] tag, [31:0] payload
//   dout       payload of the accepted data word
//   dvalid     one-cycle qualifier for dout
//   sof        marks the first dvalid of a frame
//   eof        pulse one cycle after the EOF word
//   frame_ok   pulse with eof when length and checksum both match
//   frame_err  pulse on any detected error
//   err_code   code of the most recent error (held until the next error)
//   frame_cnt  saturating count of good frames
//   err_cnt    saturating count of errors
//
// Error codes: 1 truncated frame, 2 length mismatch, 3 checksum mismatch,
// 4 bad header length or overlength, 5 orphan DATA/EOF, 6 illegal tag.

module link_frame_check #(
  parameter int MAX_LEN = 1023,
  parameter int CNTW    = 10,
  parameter int SETTLE  = 4
) (
  input  logic        clk,
  input  logic        init,
  input  logic [35:0] datain,
  output logic [31:0] dout,
  output logic        dvalid,
  output logic        sof,
  output logic        eof,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [2:0]  err_code,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam int              SW        = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SW-1:0]   SETTLE_W  = SW'(SETTLE);
  localparam logic [CNTW-1:0] MAX_LEN_W = CNTW'(MAX_LEN);

  localparam logic [3:0] TAG_IDLE = 4'h0;
  localparam logic [3:0] TAG_SOF  = 4'h1;
  localparam logic [3:0] TAG_DATA = 4'h2;
  localparam logic [3:0] TAG_EOF  = 4'h4;

  localparam logic [2:0] E_TRUNC  = 3'd1;
  localparam logic [2:0] E_LEN    = 3'd2;
  localparam logic [2:0] E_SUM    = 3'd3;
  localparam logic [2:0] E_HDR    = 3'd4;
  localparam logic [2:0] E_ORPHAN = 3'd5;
  localparam logic [2:0] E_TAG    = 3'd6;

  typedef enum logic [1:0] {
    S_SETTLE,
    S_IDLE,
    S_BODY,
    S_DISCARD
  } state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   settle, settle_nxt;
  logic [CNTW-1:0] count, count_nxt;
  logic [CNTW-1:0] exp_len, exp_len_nxt;
  logic [31:0]     sum, sum_nxt;
  logic            first, first_nxt;

  logic [31:0]     dout_nxt;
  logic            dvalid_nxt, sof_nxt, eof_nxt, ok_nxt, err_nxt;
  logic [2:0]      code_nxt;
  logic            good_inc;
  logic [1:0]      err_inc;
  logic            take_hdr;

  logic [3:0]      tag;
  logic [31:0]     payload;
  logic [CNTW-1:0] hdr_len;
  logic            hdr_ok;
  logic [16:0]     err_sum;

  assign tag     = datain[35:32];
  assign payload = datain[31:0];
  assign hdr_len = datain[CNTW-1:0];
  assign hdr_ok  = (hdr_len != '0) && (hdr_len <= MAX_LEN_W);

  // A SOF seen inside BODY can raise two errors at once (truncation plus a
  // rejected header), so the error counter adds up to two per cycle.
  assign err_sum = {1'b0, err_cnt} + {15'd0, err_inc};

  always_comb begin
    state_nxt   = state;
    settle_nxt  = settle;
    count_nxt   = count;
    exp_len_nxt = exp_len;
    sum_nxt     = sum;
    first_nxt   = first;
    dout_nxt    = dout;
    dvalid_nxt  = 1'b0;
    sof_nxt     = 1'b0;
    eof_nxt     = 1'b0;
    ok_nxt      = 1'b0;
    err_nxt     = 1'b0;
    code_nxt    = err_code;
    good_inc    = 1'b0;
    err_inc     = 2'd0;
    take_hdr    = 1'b0;

    case (state)
      S_SETTLE: begin
        // Leave after exactly SETTLE cycles with init low.
        if (settle <= SW'(1)) begin
          state_nxt = S_IDLE;
        end else begin
          settle_nxt = settle - SW'(1);
        end
      end

      S_IDLE: begin
        case (tag)
          TAG_IDLE: ;
          TAG_SOF: take_hdr = 1'b1;
          TAG_DATA, TAG_EOF: begin
            err_nxt  = 1'b1;
            code_nxt = E_ORPHAN;
            err_inc  = 2'd1;
          end
          default: begin
            err_nxt  = 1'b1;
            code_nxt = E_TAG;
            err_inc  = 2'd1;
          end
        endcase
      end

      S_BODY: begin
        case (tag)
          TAG_IDLE: ;
          TAG_DATA: begin
            if (count == exp_len) begin
              err_nxt   = 1'b1;
              code_nxt  = E_HDR;
              err_inc   = 2'd1;
              state_nxt = S_DISCARD;
            end else begin
              dout_nxt   = payload;
              dvalid_nxt = 1'b1;
              sof_nxt    = first;
              first_nxt  = 1'b0;
              count_nxt  = count + CNTW'(1);
              sum_nxt    = sum + payload;
            end
          end
          TAG_EOF: begin
            eof_nxt   = 1'b1;
            state_nxt = S_IDLE;
            // Length is judged before checksum.
            if (count != exp_len) begin
              err_nxt  = 1'b1;
              code_nxt = E_LEN;
              err_inc  = 2'd1;
            end else if (sum != payload) begin
              err_nxt  = 1'b1;
              code_nxt = E_SUM;
              err_inc  = 2'd1;
            end else begin
              ok_nxt   = 1'b1;
              good_inc = 1'b1;
            end
          end
          TAG_SOF: begin
            err_nxt  = 1'b1;
            code_nxt = E_TRUNC;
            err_inc  = 2'd1;
            take_hdr = 1'b1;
          end
          default: begin
            err_nxt   = 1'b1;
            code_nxt  = E_TAG;
            err_inc   = 2'd1;
            state_nxt = S_DISCARD;
          end
        endcase
      end

      S_DISCARD: begin
        case (tag)
          TAG_SOF: take_hdr = 1'b1;
          TAG_EOF: state_nxt = S_IDLE;
          default: ;
        endcase
      end

      default: state_nxt = S_SETTLE;
    endcase

    // Header handling shared by IDLE, BODY (restart) and DISCARD.
    if (take_hdr) begin
      if (hdr_ok) begin
        state_nxt   = S_BODY;
        count_nxt   = '0;
        sum_nxt     = '0;
        exp_len_nxt = hdr_len;
        first_nxt   = 1'b1;
      end else begin
        state_nxt = S_IDLE;
        err_nxt   = 1'b1;
        code_nxt  = E_HDR;
        err_inc   = err_inc + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state     <= S_SETTLE;
      settle    <= SETTLE_W;
      count     <= '0;
      exp_len   <= '0;
      sum       <= '0;
      first     <= 1'b0;
      dout      <= '0;
      dvalid    <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 3'd0;
      frame_cnt <= 16'd0;
      err_cnt   <= 16'd0;
    end else begin
      state     <= state_nxt;
      settle    <= settle_nxt;
      count     <= count_nxt;
      exp_len   <= exp_len_nxt;
      sum       <= sum_nxt;
      first     <= first_nxt;
      dout      <= dout_nxt;
      dvalid    <= dvalid_nxt;
      sof       <= sof_nxt;
      eof       <= eof_nxt;
      frame_ok  <= ok_nxt;
      frame_err <= err_nxt;
      err_code  <= code_nxt;
      frame_cnt <= (good_inc && (frame_cnt != 16'hFFFF)) ? frame_cnt + 16'd1 : frame_cnt;
      err_cnt   <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

endmodule

// File: tb/tb_link_frame_check.sv
// tb_link_frame_check
// -------------------
// Directed bench for link_frame_check. Each word is driven on the falling
// edge and the registered response is sampled 1 time unit after the next
// rising edge. Expected values are worked out by hand for each step.
//
// Ports of the DUT are all connected; no ports on this module.

module tb_link_frame_check;

  localparam logic [3:0] T_IDLE = 4'h0;
  localparam logic [3:0] T_SOF  = 4'h1;
  localparam logic [3:0] T_DATA = 4'h2;
  localparam logic [3:0] T_EOF  = 4'h4;
  localparam logic [3:0] T_BAD  = 4'h8;

  // Flag vector order: {dvalid, sof, eof, frame_ok, frame_err}
  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_DV   = 5'b10000;
  localparam logic [4:0] F_DVSF = 5'b11000;
  localparam logic [4:0] F_OK   = 5'b00110;
  localparam logic [4:0] F_EER  = 5'b00101;
  localparam logic [4:0] F_ER   = 5'b00001;

  logic        clk = 1'b0;
  logic        init;
  logic [35:0] datain;
  logic [31:0] dout;
  logic        dvalid, sof, eof, frame_ok, frame_err;
  logic [2:0]  err_code;
  logic [15:0] frame_cnt, err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  link_frame_check #(
    .MAX_LEN(1023),
    .CNTW   (10),
    .SETTLE (4)
  ) dut (
    .clk      (clk),
    .init     (init),
    .datain   (datain),
    .dout     (dout),
    .dvalid   (dvalid),
    .sof      (sof),
    .eof      (eof),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .err_code (err_code),
    .frame_cnt(frame_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] tag, input logic [31:0] pl);
    @(negedge clk);
    datain = {tag, pl};
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed=%h expected=%h", name, observed, expected);
    end
  endtask

  task automatic checkFlags(input string name, input logic [4:0] expected);
    checkOutput(name, {27'd0, dvalid, sof, eof, frame_ok, frame_err}, {27'd0, expected});
  endtask

  initial begin
    init   = 1'b1;
    datain = '0;
    repeat (3) @(posedge clk);
    #1;
    checkFlags("reset_flags", F_NONE);
    checkOutput("reset_dout", dout, 32'h0);
    checkOutput("reset_code", {29'd0, err_code}, 32'd0);
    checkOutput("reset_fcnt", {16'd0, frame_cnt}, 32'd0);
    checkOutput("reset_ecnt", {16'd0, err_cnt}, 32'd0);

    // Settle window: four SOF headers are ignored, the fifth is accepted.
    init = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(T_SOF, 32'd2);
      checkFlags("settle_ignore", F_NONE);
    end
    checkOutput("settle_ecnt", {16'd0, err_cnt}, 32'd0);
    applyStimulus(T_SOF, 32'd2);          checkFlags("settle_sof", F_NONE);
    applyStimulus(T_DATA, 32'h10);        checkFlags("settle_d0", F_DVSF);
    checkOutput("settle_dout0", dout, 32'h10);
    applyStimulus(T_DATA, 32'h20);        checkFlags("settle_d1", F_DV);
    checkOutput("settle_dout1", dout, 32'h20);
    applyStimulus(T_EOF, 32'h30);         checkFlags("settle_eof", F_OK);
    checkOutput("settle_fcnt", {16'd0, frame_cnt}, 32'd1);
    checkOutput("settle_ecnt2", {16'd0, err_cnt}, 32'd0);

    // Good frame, checksum wraps mod 2^32: 1 + 2 + FFFFFFFF = 2.
    applyStimulus(T_SOF, 32'd3);          checkFlags("good_sof", F_NONE);
    applyStimulus(T_DATA, 32'h1);         checkFlags("good_d0", F_DVSF);
    checkOutput("good_dout0", dout, 32'h1);
    applyStimulus(T_DATA, 32'h2);         checkFlags("good_d1", F_DV);
    applyStimulus(T_DATA, 32'hFFFFFFFF);  checkFlags("good_d2", F_DV);
    checkOutput("good_dout2", dout, 32'hFFFFFFFF);
    applyStimulus(T_EOF, 32'h2);          checkFlags("good_eof", F_OK);
    checkOutput("good_fcnt", {16'd0, frame_cnt}, 32'd2);
    checkOutput("good_ecnt", {16'd0, err_cnt}, 32'd0);

    // Same frame with IDLE words interleaved.
    applyStimulus(T_SOF, 32'd3);          checkFlags("ilv_sof", F_NONE);
    applyStimulus(T_IDLE, 32'h0);         checkFlags("ilv_i0", F_NONE);
    applyStimulus(T_DATA, 32'h1);         checkFlags("ilv_d0", F_DVSF);
    applyStimulus(T_IDLE, 32'h0);         checkFlags("ilv_i1", F_NONE);
    applyStimulus(T_DATA, 32'h2);         checkFlags("ilv_d1", F_DV);
    applyStimulus(T_IDLE, 32'hDEAD);      checkFlags("ilv_i2", F_NONE);
    applyStimulus(T_DATA, 32'hFFFFFFFF);  checkFlags("ilv_d2", F_DV);
    applyStimulus(T_IDLE, 32'h0);         checkFlags("ilv_i3", F_NONE);
    applyStimulus(T_EOF, 32'h2);          checkFlags("ilv_eof", F_OK);
    checkOutput("ilv_fcnt", {16'd0, frame_cnt}, 32'd3);

    // Length error.
    applyStimulus(T_SOF, 32'd2);          checkFlags("len_sof", F_NONE);
    applyStimulus(T_DATA, 32'h7);         checkFlags("len_d0", F_DVSF);
    applyStimulus(T_EOF, 32'h7);          checkFlags("len_eof", F_EER);
    checkOutput("len_code", {29'd0, err_code}, 32'd2);
    checkOutput("len_ecnt", {16'd0, err_cnt}, 32'd1);

    // Checksum error.
    applyStimulus(T_SOF, 32'd1);          checkFlags("sum_sof", F_NONE);
    applyStimulus(T_DATA, 32'h5);         checkFlags("sum_d0", F_DVSF);
    applyStimulus(T_EOF, 32'h6);          checkFlags("sum_eof", F_EER);
    checkOutput("sum_code", {29'd0, err_code}, 32'd3);
    checkOutput("sum_ecnt", {16'd0, err_cnt}, 32'd2);
    checkOutput("sum_fcnt", {16'd0, frame_cnt}, 32'd3);

    // Overlength: second DATA rejected, then EOF swallowed by DISCARD.
    applyStimulus(T_SOF, 32'd1);          checkFlags("ovl_sof", F_NONE);
    applyStimulus(T_DATA, 32'h9);         checkFlags("ovl_d0", F_DVSF);
    applyStimulus(T_DATA, 32'hA);         checkFlags("ovl_d1", F_ER);
    checkOutput("ovl_code", {29'd0, err_code}, 32'd4);
    applyStimulus(T_EOF, 32'h9);          checkFlags("ovl_eof", F_NONE);
    checkOutput("ovl_ecnt", {16'd0, err_cnt}, 32'd3);

    // Illegal tag in BODY, then a SOF taken directly from DISCARD.
    applyStimulus(T_SOF, 32'd2);          checkFlags("bad_sof", F_NONE);
    applyStimulus(T_DATA, 32'h1);         checkFlags("bad_d0", F_DVSF);
    applyStimulus(T_BAD, 32'h0);          checkFlags("bad_tag", F_ER);
    checkOutput("bad_code", {29'd0, err_code}, 32'd6);
    applyStimulus(T_DATA, 32'h3);         checkFlags("bad_drop", F_NONE);
    applyStimulus(T_SOF, 32'd1);          checkFlags("dis_sof", F_NONE);
    applyStimulus(T_DATA, 32'h4);         checkFlags("dis_d0", F_DVSF);
    applyStimulus(T_EOF, 32'h4);          checkFlags("dis_eof", F_OK);
    checkOutput("dis_ecnt", {16'd0, err_cnt}, 32'd4);
    checkOutput("dis_fcnt", {16'd0, frame_cnt}, 32'd4);

    // Truncated frame restarts with the new header.
    applyStimulus(T_SOF, 32'd4);          checkFlags("trn_sof", F_NONE);
    applyStimulus(T_DATA, 32'h11);        checkFlags("trn_d0", F_DVSF);
    applyStimulus(T_SOF, 32'd1);          checkFlags("trn_sof2", F_ER);
    checkOutput("trn_code", {29'd0, err_code}, 32'd1);
    applyStimulus(T_DATA, 32'h22);        checkFlags("trn_d1", F_DVSF);
    checkOutput("trn_dout", dout, 32'h22);
    applyStimulus(T_EOF, 32'h22);         checkFlags("trn_eof", F_OK);
    checkOutput("trn_fcnt", {16'd0, frame_cnt}, 32'd5);
    checkOutput("trn_code_hold", {29'd0, err_code}, 32'd1);
    checkOutput("trn_ecnt", {16'd0, err_cnt}, 32'd5);

    // Orphan DATA in IDLE.
    applyStimulus(T_DATA, 32'h33);        checkFlags("orp_data", F_ER);
    checkOutput("orp_code", {29'd0, err_code}, 32'd5);
    checkOutput("orp_ecnt", {16'd0, err_cnt}, 32'd6);

    // SOF with N=0 is rejected and stays in IDLE, so the EOF is an orphan.
    applyStimulus(T_SOF, 32'd0);          checkFlags("n0_sof", F_ER);
    checkOutput("n0_code", {29'd0, err_code}, 32'd4);
    applyStimulus(T_EOF, 32'h0);          checkFlags("n0_eof", F_ER);
    checkOutput("n0_code2", {29'd0, err_code}, 32'd5);
    checkOutput("n0_ecnt", {16'd0, err_cnt}, 32'd8);

    // SOF with N=MAX_LEN is legal; EOF with zero words is a length error.
    applyStimulus(T_SOF, 32'd1023);       checkFlags("max_sof", F_NONE);
    applyStimulus(T_EOF, 32'h0);          checkFlags("max_eof", F_EER);
    checkOutput("max_code", {29'd0, err_code}, 32'd2);

    // Illegal tag in IDLE.
    applyStimulus(4'h3, 32'h0);           checkFlags("idle_bad", F_ER);
    checkOutput("idle_bad_code", {29'd0, err_code}, 32'd6);
    checkOutput("idle_bad_ecnt", {16'd0, err_cnt}, 32'd10);

    // Saturation: counters are preloaded one below the ceiling.
    dut.frame_cnt = 16'hFFFE;
    dut.err_cnt   = 16'hFFFE;
    applyStimulus(T_SOF, 32'd1);
    applyStimulus(T_DATA, 32'h1);
    applyStimulus(T_EOF, 32'h1);          checkFlags("sat_eof0", F_OK);
    checkOutput("sat_fcnt0", {16'd0, frame_cnt}, 32'h0000FFFF);
    applyStimulus(T_SOF, 32'd1);
    applyStimulus(T_DATA, 32'h2);
    applyStimulus(T_EOF, 32'h2);          checkFlags("sat_eof1", F_OK);
    checkOutput("sat_fcnt1", {16'd0, frame_cnt}, 32'h0000FFFF);
    applyStimulus(T_DATA, 32'h0);         checkFlags("sat_err0", F_ER);
    checkOutput("sat_ecnt0", {16'd0, err_cnt}, 32'h0000FFFF);
    applyStimulus(T_DATA, 32'h0);         checkFlags("sat_err1", F_ER);
    checkOutput("sat_ecnt1", {16'd0, err_cnt}, 32'h0000FFFF);

    // Reset in the middle of a frame.
    applyStimulus(T_SOF, 32'd2);          checkFlags("rst_sof", F_NONE);
    applyStimulus(T_DATA, 32'hAB);        checkFlags("rst_d0", F_DVSF);
    @(negedge clk);
    init   = 1'b1;
    datain = {T_EOF, 32'hAB};
    @(posedge clk);
    #1;
    checkFlags("rst_flags", F_NONE);
    checkOutput("rst_dout", dout, 32'h0);
    checkOutput("rst_code", {29'd0, err_code}, 32'd0);
    checkOutput("rst_fcnt", {16'd0, frame_cnt}, 32'd0);
    checkOutput("rst_ecnt", {16'd0, err_cnt}, 32'd0);
    init = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(T_IDLE, 32'h0);
    end
    applyStimulus(T_SOF, 32'd1);          checkFlags("post_sof", F_NONE);
    applyStimulus(T_DATA, 32'h7);         checkFlags("post_d0", F_DVSF);
    applyStimulus(T_EOF, 32'h7);          checkFlags("post_eof", F_OK);
    checkOutput("post_fcnt", {16'd0, frame_cnt}, 32'd1);
    checkOutput("post_ecnt", {16'd0, err_cnt}, 32'd0);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
